reg_write_arbiter: RTL and testbench

- Round-robin write arbiter sharing one WIDTH-bit Register (inp/en/out) among NREQ requesters.
- Grants one requester at a time, drives the Register's en and inp, and supports a bounded lock (burst) so one owner can write on consecutive cycles.
- Sits between requester logic and the shared Register; the Register's own reset is unaffected by this block.

---
 rtl/reg_write_arbiter.sv | 123 ++++++++++++
 tb/tb_reg_write_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin write arbiter that shares one WIDTH-bit
// register among NREQ requesters, with a bounded lock (burst) per grant.
//
// Optional feature: define GRANT_CNT_EN to add the grantCnt output, a
// saturating 16-bit count of write cycles (edges with regEn=1).
//
// Handshake: a requester holds req high until it sees its grant bit. Every
// cycle in which grant[i]=1 is one write of data[i] into the shared register
// at the next rising edge. The FSM state is visible on busy (1 = OWN).
module reg_write_arbiter #(
  parameter int WIDTH    = 5,
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       lock,
  input  logic [NREQ*WIDTH-1:0] data,
  output logic [NREQ-1:0]       grant,
  output logic                  regEn,
  output logic [WIDTH-1:0]      regInp,
  output logic                  busy
`ifdef GRANT_CNT_EN
  ,
  output logic [15:0]           grantCnt
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t          state_q;
  logic [NREQ-1:0] grant_q;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   owner_q;
  logic [HW-1:0]   hold_q;

  logic            win_found;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   ptr_d;
  logic [NREQ-1:0] grant_d;
  logic            stay;

  // Round-robin search: first set req bit at or after the pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = PW'(idx);
      end
    end
    ptr_d   = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
    grant_d = NREQ'(1) << win_idx;
  end

  // The owner keeps the grant only while it locks, still requests, and has
  // burst budget left; MAX_HOLD=1 makes this always false.
  assign stay = (state_q == OWN) && lock[owner_q] && req[owner_q] &&
                (hold_q < HW'(MAX_HOLD));

  // Arbiter FSM: grant, owner, burst counter and round-robin pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      hold_q  <= '0;
    end else if (stay) begin
      hold_q <= hold_q + HW'(1);
    end else if (win_found) begin
      // Release and re-arbitrate in the same edge: no idle gap between owners.
      state_q <= OWN;
      grant_q <= grant_d;
      owner_q <= win_idx;
      hold_q  <= HW'(1);
      ptr_q   <= ptr_d;
    end else begin
      state_q <= IDLE;
      grant_q <= '0;
      hold_q  <= '0;
    end
  end

  // Write data mux: AND-OR on the one-hot grant, so idle gives zero.
  always_comb begin
    regInp = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) regInp = regInp | data[i*WIDTH +: WIDTH];
    end
  end

  assign grant = grant_q;
  assign regEn = |grant_q;
  assign busy  = (state_q == OWN);

`ifdef GRANT_CNT_EN
  logic [15:0] cnt_q;

  // Saturating count of write cycles since reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (regEn && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign grantCnt = cnt_q;
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Testbench for reg_write_arbiter (NREQ=4, WIDTH=5, MAX_HOLD=4).
// Table of per-cycle vectors plus a hand-written reset-mid-grant sequence.
module tb_reg_write_arbiter;

  localparam int W = 5;
  localparam int N = 4;
  localparam int OW = N + 1 + W + 1;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    lock;
  logic [N*W-1:0]  data;
  logic [N-1:0]    grant;
  logic            regEn;
  logic [W-1:0]    regInp;
  logic            busy;
`ifdef GRANT_CNT_EN
  logic [15:0]     grantCnt;
`endif

  reg_write_arbiter #(.WIDTH(W), .NREQ(N), .MAX_HOLD(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .lock   (lock),
    .data   (data),
    .grant  (grant),
    .regEn  (regEn),
    .regInp (regInp),
    .busy   (busy)
`ifdef GRANT_CNT_EN
    ,
    .grantCnt (grantCnt)
`endif
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // shared register being written (not reset by the arbiter)
  logic [W-1:0] reg_out = '0;
  always @(posedge clk) if (regEn) reg_out <= regInp;

  typedef struct {
    logic         rst_before;
    logic [N-1:0] req;
    logic [N-1:0] lock;
    logic [N*W-1:0] data;
    logic [N-1:0] g;
    logic         en;
    logic [W-1:0] inp;
    logic         busy;
  } vec_t;

  vec_t tbl[$];
  logic [OW-1:0] exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  logic [N-1:0] prev_g;
  logic         prev_en;
  logic [W-1:0] exp_reg;
  int           exp_cnt;

  localparam logic [N*W-1:0] DA = {5'd4, 5'd3, 5'd2, 5'd1};
  localparam logic [N*W-1:0] DB = {5'd0, 5'd21, 5'd0, 5'd0};
  localparam logic [N*W-1:0] DC = {5'd4, 5'd3, 5'd2, 5'd7};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic add(input logic rb, input logic [N-1:0] rq, input logic [N-1:0] lk,
                     input logic [N*W-1:0] d, input logic [N-1:0] g, input logic en,
                     input logic [W-1:0] inp, input logic bz);
    vec_t v;
    v.rst_before = rb; v.req = rq; v.lock = lk; v.data = d;
    v.g = g; v.en = en; v.inp = inp; v.busy = bz;
    tbl.push_back(v);
  endtask

  function automatic logic [W-1:0] sel(input logic [N*W-1:0] d, input logic [N-1:0] g);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) if (g[i]) r = r | d[i*W +: W];
    return r;
  endfunction

  // driver: reset pulse with immediate zero-output check
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; req = '0; lock = '0;
    #1;
    chk("reset_out", {28'd0, grant, regEn, busy}, 32'd0);
    chk("reset_inp", {27'd0, regInp}, 32'd0);
`ifdef GRANT_CNT_EN
    chk("reset_cnt", {16'd0, grantCnt}, 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b1;
    prev_g = '0; prev_en = 1'b0; exp_cnt = 0;
  endtask

  initial begin
    rst = 1'b1; req = '0; lock = '0; data = '0;
    prev_g = '0; prev_en = 1'b0; exp_reg = '0; exp_cnt = 0;

    // reset then idle
    add(1, 4'b0000, 4'b0000, DA, 4'b0000, 0, 5'd0, 0);
    for (int i = 0; i < 4; i++) add(0, 4'b0000, 4'b0000, DA, 4'b0000, 0, 5'd0, 0);
    // round robin, pointer starts at 0
    add(0, 4'b1111, 4'b0000, DA, 4'b0001, 1, 5'd1, 1);
    add(0, 4'b1111, 4'b0000, DA, 4'b0010, 1, 5'd2, 1);
    add(0, 4'b1111, 4'b0000, DA, 4'b0100, 1, 5'd3, 1);
    add(0, 4'b1111, 4'b0000, DA, 4'b1000, 1, 5'd4, 1);
    add(0, 4'b1111, 4'b0000, DA, 4'b0001, 1, 5'd1, 1);
    add(0, 4'b0000, 4'b0000, DA, 4'b0000, 0, 5'd0, 0);
    // single request, exactly one write cycle
    add(1, 4'b0100, 4'b0000, DB, 4'b0100, 1, 5'd21, 1);
    add(0, 4'b0000, 4'b0000, DB, 4'b0000, 0, 5'd0, 0);
    add(0, 4'b0000, 4'b0000, DB, 4'b0000, 0, 5'd0, 0);
    // lock bound: 4 cycles for owner 0, then 1, then 0 again
    add(1, 4'b0011, 4'b0001, DA, 4'b0001, 1, 5'd1, 1);
    add(0, 4'b0011, 4'b0001, DA, 4'b0001, 1, 5'd1, 1);
    add(0, 4'b0011, 4'b0001, DA, 4'b0001, 1, 5'd1, 1);
    add(0, 4'b0011, 4'b0001, DA, 4'b0001, 1, 5'd1, 1);
    add(0, 4'b0011, 4'b0001, DA, 4'b0010, 1, 5'd2, 1);
    add(0, 4'b0011, 4'b0001, DA, 4'b0001, 1, 5'd1, 1);
    add(0, 4'b0000, 4'b0000, DA, 4'b0000, 0, 5'd0, 0);
    // non-owner lock ignored; owner drops req while locked
    add(1, 4'b0011, 4'b0010, DA, 4'b0001, 1, 5'd1, 1);
    add(0, 4'b0011, 4'b0010, DA, 4'b0010, 1, 5'd2, 1);
    add(0, 4'b0011, 4'b0010, DA, 4'b0010, 1, 5'd2, 1);
    add(0, 4'b0001, 4'b0010, DA, 4'b0001, 1, 5'd1, 1);
    add(0, 4'b0000, 4'b0000, DA, 4'b0000, 0, 5'd0, 0);
    // data change during OWN is written at that edge
    add(1, 4'b0001, 4'b0001, DA, 4'b0001, 1, 5'd1, 1);
    add(0, 4'b0001, 4'b0001, DC, 4'b0001, 1, 5'd7, 1);
    add(0, 4'b0000, 4'b0000, DC, 4'b0000, 0, 5'd0, 0);

    foreach (tbl[r]) begin
      if (tbl[r].rst_before) do_reset();
      @(negedge clk);
      req = tbl[r].req; lock = tbl[r].lock; data = tbl[r].data;
      exp_q.push_back({tbl[r].g, tbl[r].en, tbl[r].inp, tbl[r].busy});
      // value the shared register captures at the coming edge
      if (prev_en) begin
        exp_reg = sel(tbl[r].data, prev_g);
        exp_cnt++;
      end
      @(posedge clk);
      #1;
      begin
        logic [OW-1:0] e;
        e = exp_q.pop_front();
        chk($sformatf("row%0d_out", r), {21'd0, grant, regEn, regInp, busy}, {21'd0, e});
      end
      chk($sformatf("row%0d_reg", r), {27'd0, reg_out}, {27'd0, exp_reg});
      chk($sformatf("row%0d_onehot", r), {31'd0, $onehot0(grant)}, 32'd1);
`ifdef GRANT_CNT_EN
      chk($sformatf("row%0d_cnt", r), {16'd0, grantCnt}, exp_cnt);
`endif
      prev_g = tbl[r].g; prev_en = tbl[r].en;
    end

    // reset mid-grant: grant to requester 1 moves pointer to 2, then reset
    do_reset();
    @(negedge clk);
    req = 4'b0010; lock = '0; data = DA;
    @(posedge clk);
    #1;
    chk("mid_grant_before", {28'd0, grant}, {28'd0, 4'b0010});
    begin
      logic [W-1:0] held;
      held = reg_out;
      #3;
      rst = 1'b0;
      #1;
      chk("mid_grant_drop", {28'd0, grant, regEn, busy}, 32'd0);
      chk("mid_grant_inp", {27'd0, regInp}, 32'd0);
      @(posedge clk);
      #1;
      chk("mid_grant_nowrite", {27'd0, reg_out}, {27'd0, held});
    end
    @(negedge clk);
    rst = 1'b1; req = 4'b1001;
    @(posedge clk);
    #1;
    chk("after_reset_ptr0", {28'd0, grant}, {28'd0, 4'b0001});
    @(negedge clk);
    req = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("final_idle", {28'd0, grant, regEn, busy}, 32'd0);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
